node_streamer: RTL

NODE_STREAMER -- requirements
Module: node_streamer

---
 rtl/node_streamer_if.sv | 28 ++
 rtl/node_streamer.sv | 69 ++++++
 2 files changed

// File: rtl/node_streamer_if.sv
// Handshake bundle between node_streamer and its producer/consumer side.
// The slave modport is the streamer itself; the master modport is the one driving it.
interface node_streamer_if #(
  parameter int NODE_COUNT = 5
);
  logic                       snap_req;
  logic [NODE_COUNT*32-1:0]   nodes_x;
  logic [NODE_COUNT*32-1:0]   nodes_y;
  logic                       out_ready;
  logic                       out_valid;
  logic [31:0]                out_x;
  logic [31:0]                out_y;
  logic [7:0]                 out_node_id;
  logic                       out_last;
  logic [15:0]                out_frame;
  logic                       busy;
  logic [7:0]                 drop_count;

  modport master (
    output snap_req, nodes_x, nodes_y, out_ready,
    input  out_valid, out_x, out_y, out_node_id, out_last, out_frame, busy, drop_count
  );

  modport slave (
    input  snap_req, nodes_x, nodes_y, out_ready,
    output out_valid, out_x, out_y, out_node_id, out_last, out_frame, busy, drop_count
  );
endinterface

// File: rtl/node_streamer.sv
// Snapshots a core's node positions on request and streams them one node per beat
// over a valid/ready port; requests arriving mid-frame are counted and dropped.
module node_streamer #(
  parameter int NODE_COUNT = 5,
  parameter int CORE_ID    = 1
) (
  input logic            clk,
  input logic            reset,
  node_streamer_if.slave bus
);
  localparam int             IW       = (NODE_COUNT > 1) ? $clog2(NODE_COUNT) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(NODE_COUNT - 1);
  localparam logic [7:0]     ID_BASE  = 8'((CORE_ID - 1) * NODE_COUNT + 1);
  localparam logic [0:0]     S_IDLE   = 1'b0;
  localparam logic [0:0]     S_STREAM = 1'b1;

  logic [0:0]                   r_state;
  logic [IW-1:0]                r_idx;
  logic [NODE_COUNT-1:0][31:0]  r_sx;
  logic [NODE_COUNT-1:0][31:0]  r_sy;
  logic [15:0]                  r_frame;  // captures accepted since reset
  logic [7:0]                   r_drop;

  logic w_valid, w_xfer, w_last, w_last_xfer, w_capture, w_drop;

  assign w_valid     = (r_state == S_STREAM);
  assign w_xfer      = w_valid && bus.out_ready;
  assign w_last      = w_valid && (r_idx == LAST_IDX);
  assign w_last_xfer = w_xfer && (r_idx == LAST_IDX);
  // A request landing on the final transfer chains straight into the next frame.
  assign w_capture   = bus.snap_req && (!w_valid || w_last_xfer);
  assign w_drop      = bus.snap_req && !w_capture;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_sx    <= '0;
      r_sy    <= '0;
      r_frame <= '0;
      r_drop  <= '0;
    end else begin
      if (w_capture) begin
        r_sx    <= bus.nodes_x;
        r_sy    <= bus.nodes_y;
        r_idx   <= '0;
        r_state <= S_STREAM;
        r_frame <= r_frame + 16'd1;
      end else if (w_last_xfer) begin
        r_idx   <= '0;
        r_state <= S_IDLE;
      end else if (w_xfer) begin
        r_idx   <= r_idx + IW'(1);
      end
      if (w_drop && (r_drop != 8'hFF))
        r_drop <= r_drop + 8'd1;
    end
  end

  // Beat fields read as zero outside a frame so the port is quiet when idle.
  assign bus.out_valid   = w_valid;
  assign bus.busy        = w_valid;
  assign bus.out_x       = w_valid ? r_sx[r_idx] : 32'd0;
  assign bus.out_y       = w_valid ? r_sy[r_idx] : 32'd0;
  assign bus.out_node_id = w_valid ? (ID_BASE + 8'(r_idx)) : 8'd0;
  assign bus.out_last    = w_last;
  assign bus.out_frame   = w_valid ? (r_frame - 16'd1) : 16'd0;
  assign bus.drop_count  = r_drop;
endmodule
